// File: rtl/filter_ctrl.sv
// rtl/filter_ctrl.sv - row-fetch / 3x3-sweep sequencer for the line-buffer filter stage
//
// Purpose: fetches image rows one at a time from the memory controller. It fills
// three line buffers, then runs one 3x3 window sweep per output row. Between sweeps
// it fetches one new row into the oldest buffer.
//
// Ports:
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   start_i        start one image (accepted only in IDLE)
//   abort_i        drop the current image and return to IDLE
//   busy_o         high whenever not IDLE
//   img_done_o     one-cycle pulse at image completion
//   mem_req_o      one-cycle row fetch request, row index on mem_row_o
//   data_en_i      one pixel per cycle from the memory controller
//   core_run_o     enables one window sweep; core_done_i ends it
//   out_row_o      output row currently being swept
//   win_top_o      line buffer (0..2) holding the top window row
//   proto_err_o    sticky flag for strobes arriving in the wrong state

module filter_ctrl #(
    parameter int IMG_ROWS = 540,
    parameter int IMG_COLS = 540,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             img_done_o,
    output logic             mem_req_o,
    output logic [CNT_W-1:0] mem_row_o,
    input  logic             data_en_i,
    output logic             core_run_o,
    input  logic             core_done_i,
    output logic [CNT_W-1:0] out_row_o,
    output logic [1:0]       win_top_o,
    output logic             proto_err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FETCH = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COL     = CNT_W'(IMG_COLS - 1);
    localparam logic [CNT_W-1:0] LAST_OUT_ROW = CNT_W'(IMG_ROWS - 3);
    // Rows 0 and 1 complete without filling the window; after row 2 we can sweep.
    localparam logic [CNT_W-1:0] FILL_LAST    = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fetch_row_q, fetch_row_d;
    logic [CNT_W-1:0] out_row_q, out_row_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]       win_top_q, win_top_d;
    logic             proto_err_q, proto_err_d;
    logic             proto_viol;

    // A strobe outside its own state is flagged but otherwise ignored.
    assign proto_viol = (data_en_i && (state_q != FETCH)) ||
                        (core_done_i && (state_q != RUN));

    always_comb begin
        state_d     = state_q;
        fetch_row_d = fetch_row_q;
        out_row_d   = out_row_q;
        col_cnt_d   = col_cnt_q;
        win_top_d   = win_top_q;
        proto_err_d = proto_err_q | proto_viol;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    fetch_row_d = '0;
                    out_row_d   = '0;
                    col_cnt_d   = '0;
                    win_top_d   = 2'd0;
                    proto_err_d = 1'b0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                state_d = abort_i ? IDLE : FETCH;
            end
            FETCH: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (data_en_i) begin
                    if (col_cnt_q == LAST_COL) begin
                        col_cnt_d   = '0;
                        fetch_row_d = fetch_row_q + 1'b1;
                        // Compare against the pre-increment row: new row < 3.
                        state_d     = (fetch_row_q < FILL_LAST) ? REQ : RUN;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (core_done_i) begin
                    if (out_row_q == LAST_OUT_ROW) begin
                        state_d = DONE;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                        win_top_d = (win_top_q == 2'd2) ? 2'd0 : win_top_q + 2'd1;
                        state_d   = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_row_q <= '0;
            out_row_q   <= '0;
            col_cnt_q   <= '0;
            win_top_q   <= 2'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_row_q <= fetch_row_d;
            out_row_q   <= out_row_d;
            col_cnt_q   <= col_cnt_d;
            win_top_q   <= win_top_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign img_done_o  = (state_q == DONE);
    assign mem_req_o   = (state_q == REQ);
    assign core_run_o  = (state_q == RUN);
    assign mem_row_o   = fetch_row_q;
    assign out_row_o   = out_row_q;
    assign win_top_o   = win_top_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// tb/tb_filter_ctrl.sv - self-checking bench for filter_ctrl
module tb_filter_ctrl;

    localparam int COLS   = 4;
    localparam int ROWS_A = 5;
    localparam int ROWS_B = 3;
    localparam int CW     = 10;

    logic clk = 1'b0;
    logic rst, start, abort, data_en, core_done;
    always #5 clk = ~clk;

    logic a_busy, a_done, a_req, a_run, a_err;
    logic [CW-1:0] a_row, a_out;
    logic [1:0] a_top;
    logic b_busy, b_done, b_req, b_run, b_err;
    logic [CW-1:0] b_row, b_out;
    logic [1:0] b_top;

    filter_ctrl #(.IMG_ROWS(ROWS_A), .IMG_COLS(COLS), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .busy_o(a_busy), .img_done_o(a_done), .mem_req_o(a_req), .mem_row_o(a_row),
        .data_en_i(data_en), .core_run_o(a_run), .core_done_i(core_done),
        .out_row_o(a_out), .win_top_o(a_top), .proto_err_o(a_err)
    );

    filter_ctrl #(.IMG_ROWS(ROWS_B), .IMG_COLS(COLS), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .busy_o(b_busy), .img_done_o(b_done), .mem_req_o(b_req), .mem_row_o(b_row),
        .data_en_i(data_en), .core_run_o(b_run), .core_done_i(core_done),
        .out_row_o(b_out), .win_top_o(b_top), .proto_err_o(b_err)
    );

    int sel = 0;
    logic o_busy, o_done, o_req, o_run, o_err;
    logic [CW-1:0] o_row, o_out;
    logic [1:0] o_top;
    always_comb begin
        o_busy = sel ? b_busy : a_busy;
        o_done = sel ? b_done : a_done;
        o_req  = sel ? b_req  : a_req;
        o_run  = sel ? b_run  : a_run;
        o_err  = sel ? b_err  : a_err;
        o_row  = sel ? b_row  : a_row;
        o_out  = sel ? b_out  : a_out;
        o_top  = sel ? b_top  : a_top;
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic s, input logic a, input logic d, input logic c, input logic r);
        start = s; abort = a; data_en = d; core_done = c; rst = r;
        @(posedge clk);
        #1;
        start = 0; abort = 0; data_en = 0; core_done = 0; rst = 0;
    endtask

    typedef struct {
        logic r, s, a, d, c;
        logic busy, req;
        int   row;
        logic run, done, err;
    } vec_t;

    // Responder: serves fetches with COLS beats (random gaps) and sweeps with
    // random latency; records what the DUT requested and swept, then compares
    // against the image rules: rows 0..R-1, sweeps 0..R-3, top = sweep mod 3.
    task automatic run_image(input int gap, input int lat_lo, input int lat_hi,
                             input int inject_sweep, input int abort_sweep);
        int rows;
        int req_q[$];
        int sw_row[$];
        int sw_top[$];
        int done_n, beats_left, early, wait_c, nsweep, bad, seen;
        bit prev_run, finished, aborted, injected;
        logic s_a, s_d, s_c;
        rows = sel ? ROWS_B : ROWS_A;
        done_n = 0; beats_left = 0; early = 0; wait_c = 0; nsweep = 0;
        prev_run = 0; finished = 0; aborted = 0; injected = 0;
        cyc(1, 0, 0, 0, 0);
        for (int t = 0; t < 3000 && !finished; t++) begin
            s_a = 0; s_d = 0; s_c = 0;
            if (o_req) begin
                if (beats_left != 0) early++;
                req_q.push_back(int'(o_row));
                beats_left = COLS;
            end
            if (o_done) begin
                done_n++;
                finished = 1;
            end
            if (o_run && !prev_run) begin
                sw_row.push_back(int'(o_out));
                sw_top.push_back(int'(o_top));
                wait_c = $urandom_range(lat_hi, lat_lo);
                if (nsweep == inject_sweep) begin s_d = 1; injected = 1; end
                if (nsweep == abort_sweep) s_a = 1;
                nsweep++;
            end
            prev_run = o_run;
            if (!finished) begin
                if (o_busy && !o_req && !o_run && beats_left > 0 &&
                    $urandom_range(99, 0) >= gap) begin
                    s_d = 1;
                    beats_left--;
                end else if (o_run && !s_a) begin
                    if (wait_c == 0) s_c = 1;
                    else wait_c--;
                end
                cyc(0, s_a, s_d, s_c, 0);
                if (s_a) begin
                    aborted = 1;
                    finished = 1;
                    chk("abort_run_low", o_run, 0);
                    chk("abort_busy_low", o_busy, 0);
                end
            end
        end
        chk("image_finished_in_budget", finished, 1);
        if (aborted) begin
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (o_done || o_busy) seen++;
                cyc(0, 0, 0, 0, 0);
            end
            chk("no_activity_after_abort", seen, 0);
            cyc(1, 0, 0, 0, 0);
            chk("restart_req", o_req, 1);
            chk("restart_row", int'(o_row), 0);
            cyc(0, 1, 0, 0, 0);
        end else begin
            chk("req_count", req_q.size(), rows);
            bad = 0;
            foreach (req_q[i]) if (req_q[i] != i) bad++;
            chk("req_rows_in_order", bad, 0);
            chk("sweep_count", sw_row.size(), rows - 2);
            bad = 0;
            foreach (sw_row[i]) if (sw_row[i] != i || sw_top[i] != i % 3) bad++;
            chk("sweep_row_and_top", bad, 0);
            chk("done_pulses", done_n, 1);
            chk("no_early_req", early, 0);
            chk("proto_err_end", o_err, int'(injected));
            cyc(0, 0, 0, 0, 0);
            chk("idle_after_done", o_busy, 0);
            chk("done_one_cycle", o_done, 0);
        end
    endtask

    initial begin
        vec_t vt[$];
        int bad;
        rst = 1; start = 0; abort = 0; data_en = 0; core_done = 0;
        sel = 0;

        vt.push_back('{1,0,0,0,0, 0,0,0,0,0,0});
        vt.push_back('{0,0,0,0,0, 0,0,0,0,0,0});
        vt.push_back('{0,0,0,1,0, 0,0,0,0,0,1});
        vt.push_back('{0,1,0,0,0, 1,1,0,0,0,0});
        vt.push_back('{0,0,0,0,0, 1,0,0,0,0,0});
        vt.push_back('{0,0,0,1,0, 1,0,0,0,0,0});
        vt.push_back('{0,0,0,1,0, 1,0,0,0,0,0});
        vt.push_back('{1,1,0,1,0, 0,0,0,0,0,0});
        vt.push_back('{0,1,0,0,0, 1,1,0,0,0,0});
        vt.push_back('{0,0,0,0,0, 1,0,0,0,0,0});
        vt.push_back('{0,0,0,0,1, 1,0,0,0,0,1});
        vt.push_back('{0,0,0,1,0, 1,0,0,0,0,1});
        vt.push_back('{0,0,0,1,0, 1,0,0,0,0,1});
        vt.push_back('{0,0,0,1,0, 1,0,0,0,0,1});
        vt.push_back('{0,0,0,1,0, 1,1,1,0,0,1});
        vt.push_back('{0,1,0,0,0, 1,0,1,0,0,1});
        vt.push_back('{0,0,1,0,0, 0,0,1,0,0,1});
        vt.push_back('{0,1,0,0,0, 1,1,0,0,0,0});
        vt.push_back('{0,0,1,0,0, 0,0,0,0,0,0});

        foreach (vt[i]) begin
            cyc(vt[i].s, vt[i].a, vt[i].d, vt[i].c, vt[i].r);
            bad = 0;
            if (o_busy != vt[i].busy) bad++;
            if (o_req  != vt[i].req)  bad++;
            if (int'(o_row) != vt[i].row) bad++;
            if (o_run  != vt[i].run)  bad++;
            if (o_done != vt[i].done) bad++;
            if (o_err  != vt[i].err)  bad++;
            if (bad != 0)
                $display("FAIL vec%0d: busy=%0b req=%0b row=%0d run=%0b done=%0b err=%0b expected busy=%0b req=%0b row=%0d run=%0b done=%0b err=%0b",
                         i, o_busy, o_req, o_row, o_run, o_done, o_err,
                         vt[i].busy, vt[i].req, vt[i].row, vt[i].run, vt[i].done, vt[i].err);
            total++;
            if (bad == 0) pass_cnt++;
        end

        chk("reset_out_row", int'(o_out), 0);
        chk("reset_win_top", int'(o_top), 0);

        run_image(0, 6, 6, -1, -1);
        run_image(50, 6, 6, -1, -1);
        run_image(0, 2, 4, 1, -1);
        cyc(1, 0, 0, 0, 0);
        chk("start_clears_err", o_err, 0);
        chk("start_req_row0", int'(o_row), 0);
        cyc(0, 1, 0, 0, 0);
        run_image(0, 3, 3, -1, 1);

        for (int k = 0; k < 4; k++)
            run_image($urandom_range(70, 0), 0, 8, -1, -1);

        sel = 1;
        cyc(0, 0, 0, 0, 1);
        run_image(0, 6, 6, -1, -1);
        run_image(40, 0, 5, -1, -1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/filter_ctrl.md
FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 SHALL have parameter IMG_ROWS, default 540, image height in rows (min 3).
REQ-002 SHALL have parameter IMG_COLS, default 540, image width in pixels (min 3).
REQ-003 SHALL have parameter CNT_W, default 10, width of the row and column counters.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  one-cycle request to start processing one image.
REQ-007 SHALL have port abort_i  in  1  one-cycle request to stop the current image.
REQ-008 SHALL have port busy_o  out  1  high in every state other than IDLE.
REQ-009 SHALL have port img_done_o  out  1  one-cycle pulse when the image completes.
REQ-010 SHALL have port mem_req_o  out  1  one-cycle row fetch request to the memory controller.
REQ-011 SHALL have port mem_row_o  out  CNT_W  index of the requested image row.
REQ-012 SHALL have port data_en_i  in  1  pixel-valid strobe from the memory controller (one pixel per cycle).
REQ-013 SHALL have port core_run_o  out  1  enables one 3x3 window sweep in the line-buffer/preprocess stage.
REQ-014 SHALL have port core_done_i  in  1  one-cycle pulse marking the end of a sweep.
REQ-015 SHALL have port out_row_o  out  CNT_W  index of the output row being swept.
REQ-016 SHALL have port win_top_o  out  2  index (0..2) of the line buffer holding the top window row.
REQ-017 SHALL have port proto_err_o  out  1  sticky protocol-error flag.

Function
REQ-018 SHALL implement the FSM states IDLE, REQ, FETCH, RUN and DONE.
REQ-019 IDLE: when start_i=1, SHALL clear fetch_row, out_row, col_cnt, win_top and proto_err, then go to REQ; start_i SHALL be ignored in every other state.
REQ-020 REQ: SHALL drive mem_req_o=1 for exactly one cycle with mem_row_o=fetch_row, then go to FETCH.
REQ-021 FETCH: on each data_en_i=1, col_cnt SHALL increment.
REQ-022 FETCH, row end: when data_en_i=1 with col_cnt=IMG_COLS-1, SHALL set col_cnt to 0 and increment fetch_row in that cycle.
REQ-023 FETCH, initial fill: on row end, if the new fetch_row < 3, SHALL go to REQ, otherwise SHALL go to RUN.
REQ-024 RUN: core_run_o SHALL be 1 from the first RUN cycle until the cycle in which core_done_i=1 is sampled, inclusive.
REQ-025 RUN: core_run_o SHALL be 0 in all other states.
REQ-026 RUN, last sweep: on core_done_i with out_row=IMG_ROWS-3, SHALL go to DONE.
REQ-027 RUN, other sweeps: on core_done_i otherwise, SHALL increment out_row, advance win_top modulo 3 (2->0), and go to REQ to fetch row fetch_row (one new row replaces the oldest buffer).
REQ-028 DONE: SHALL assert img_done_o for one cycle, then go to IDLE.
REQ-029 An image SHALL produce exactly IMG_ROWS-2 sweeps and issue exactly IMG_ROWS mem_req_o pulses.
REQ-030 mem_row_o SHALL equal fetch_row at all times, so it is held stable while mem_req_o=1.
REQ-031 out_row_o SHALL equal out_row at all times; win_top_o SHALL equal win_top at all times.
REQ-032 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge: core_run_o=0 and no img_done_o; abort_i SHALL take priority over every other transition in that cycle.
REQ-033 proto_err_o SHALL set if data_en_i=1 in any state other than FETCH, or if core_done_i=1 in any state other than RUN.
REQ-034 proto_err_o SHALL hold once set, and SHALL be cleared only by rst or by an accepted start_i.
REQ-035 data_en_i or core_done_i arriving outside its valid state SHALL NOT change any counter or the FSM state.
REQ-036 All counters SHALL be CNT_W bits wide (win_top 2 bits) and SHALL wrap only as specified above, never by overflow.

Reset
REQ-037 rst=1 SHALL force IDLE on the next edge and set every output, counter and win_top to 0, overriding all other inputs, including mid-fetch and mid-sweep.
REQ-038 In the cycle after rst deasserts, the block SHALL accept start_i.

Verification
REQ-039 With IMG_ROWS=5, IMG_COLS=4: start, 4-beat bursts after each request, core_done_i 6 cycles after core_run_o rises -> mem_req_o pulses for rows 0,1,2,3,4; out_row_o sequence 0,1,2; win_top_o sequence 0,1,2; one img_done_o pulse; busy_o=0 afterwards.
REQ-040 During FETCH, gaps in data_en_i (beat, idle, beat, idle) -> the row completes only after 4 beats; mem_req_o is not reissued early.
REQ-041 IMG_ROWS=3 -> exactly 3 requests, one sweep, then img_done_o.
REQ-042 abort_i pulsed during the second sweep -> core_run_o=0 and busy_o=0 on the next cycle, no img_done_o; a following start_i re-requests row 0.
REQ-043 data_en_i=1 during RUN -> proto_err_o=1 and sticky, col_cnt unchanged; the next start_i clears the flag.
REQ-044 rst asserted mid-FETCH (col_cnt=2) -> all outputs 0 on the next cycle; start_i in the cycle after rst deasserts -> mem_req_o issued for row 0.
